// File: rtl/bist_pkg.sv
// Shared definitions for the BIST command path: data-register width, loader
// state encoding and the command/data byte split used by the buffer and decoder.
package bist_pkg;

  localparam int DR_WIDTH = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CAP   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam int CMD_MSB  = 15;
  localparam int CMD_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/bist_dr_loader.sv
// Serial-to-parallel data-register loader: captures a status word, shifts an
// instruction word in LSB-first, and writes it to the BIST buffer on a well-framed update.
module bist_dr_loader
  import bist_pkg::*;
#(
  parameter int DR_WIDTH = bist_pkg::DR_WIDTH,
  parameter int CNT_W    = 5
) (
  input  logic                clk,
  input  logic                Loader_res,
  input  logic                Capture_dr,
  input  logic                Shift_dr,
  input  logic                Update_dr,
  input  logic                Tdi,
  input  logic [DR_WIDTH-1:0] Status_in,
  output logic                Tdo,
  output logic                Bufer_write_en,
  output logic [DR_WIDTH-1:0] Bufer_out,
  output logic                Frame_err,
  output logic                Busy
);

  logic [1:0]          r_state;
  logic [DR_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_write_en;
  logic [DR_WIDTH-1:0] r_bufer_out;
  logic                r_frame_err;

  logic                w_cnt_full;
  assign w_cnt_full = (r_cnt == CNT_W'(DR_WIDTH));

  // Branch order encodes event priority: reset, capture, update, shift.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge
    // state; the strobe default makes Bufer_write_en a single-cycle pulse.
    r_write_en <= 1'b0;
    if (Loader_res) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_bufer_out <= '0;
      r_frame_err <= 1'b0;
    end else if (Capture_dr) begin
      r_state     <= ST_CAP;
      r_sr        <= Status_in;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else if (Update_dr) begin
      if (r_state == ST_SHIFT && w_cnt_full) begin
        r_bufer_out <= r_sr;
        r_write_en  <= 1'b1;
        r_state     <= ST_IDLE;
      end else if (r_state != ST_IDLE) begin
        r_frame_err <= 1'b1;
        r_state     <= ST_IDLE;
      end
    end else if (Shift_dr && r_state != ST_IDLE) begin
      r_sr    <= {Tdi, r_sr[DR_WIDTH-1:1]};
      // Saturate so a long over-shift can never alias back to a legal count.
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      r_state <= ST_SHIFT;
    end
  end

  assign Tdo            = r_sr[0];
  assign Bufer_write_en = r_write_en;
  assign Bufer_out      = r_bufer_out;
  assign Frame_err      = r_frame_err;
  assign Busy           = (r_state != ST_IDLE);

endmodule
